// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;
  localparam int XLEN         = 32;
  localparam int MULDIV_ITERS = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// Datapath: 64-bit accumulator/remainder register, one radix-2 shift-add or
// restoring-divide step per cycle, and the final sign correction.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic            neg_i,
  input  logic [XLEN-1:0] op_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] result_o
);
  logic [XLEN-1:0]   op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_neg;
  logic [XLEN:0]     add_sum, sub_shf, sub_diff;
  logic [XLEN-1:0]   hi_fix, lo_fix;

  // op holds multiplicand (mul) or divisor (div); acc low half starts as
  // multiplier or dividend and is shifted out as the step proceeds.
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
    sub_shf  = acc_q[2*XLEN-1:XLEN-1];
    sub_diff = sub_shf - {1'b0, op_q};
    if (load_i) begin
      op_d  = op_i;
      acc_d = {{XLEN{1'b0}}, lo_i};
    end else if (step_i) begin
      if (funct3_i[2]) begin
        // partial remainder stays below the divisor, so bit XLEN is the borrow
        if (!sub_diff[XLEN]) acc_d = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_d = {sub_shf[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {add_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Result is taken from the next accumulator value so the final step lands
  // in the output register on the same edge that enters DONE.
  always_comb begin
    acc_neg = neg_i ? -acc_d : acc_d;
    hi_fix  = neg_i ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    lo_fix  = neg_i ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    if (!funct3_i[2])
      result_o = (funct3_i[1:0] == 2'b00) ? acc_neg[XLEN-1:0] : acc_neg[2*XLEN-1:XLEN];
    else if (funct3_i[1])
      result_o = hi_fix;
    else
      result_o = lo_fix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q  <= '0;
      acc_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: FSM, counter, special cases, result regs.
// Define MULDIV_FAST_MUL_EN to complete multiplies in one cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  muldiv_state_t   state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d, rd_pend_q, rd_pend_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;

  logic            accept, s1, s2, is_div, div_zero, div_ovf, neg_in;
  logic [XLEN-1:0] m1, m2, spec_res, core_res;
  logic            core_load, core_step;

  assign accept = start_i & (state_q == IDLE) & ~flush_i;
  assign busy_o = (state_q == CALC) | accept;

  always_comb begin
    s1       = rs1_signed(funct3_i) & rs1_i[XLEN-1];
    s2       = rs2_signed(funct3_i) & rs2_i[XLEN-1];
    m1       = s1 ? -rs1_i : rs1_i;
    m2       = s2 ? -rs2_i : rs2_i;
    is_div   = funct3_i[2];
    div_zero = is_div & (rs2_i == '0);
    div_ovf  = is_div & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
    // remainder follows the dividend sign; quotient/product follows the xor
    neg_in   = (is_div & funct3_i[1]) ? s1 : (s1 ^ s2);
    if (div_zero) spec_res = funct3_i[1] ? rs1_i : '1;
    else          spec_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fp;
  always_comb begin
    fa = rs1_signed(funct3_i) ? {{XLEN{rs1_i[XLEN-1]}}, rs1_i} : {{XLEN{1'b0}}, rs1_i};
    fb = rs2_signed(funct3_i) ? {{XLEN{rs2_i[XLEN-1]}}, rs2_i} : {{XLEN{1'b0}}, rs2_i};
    fp = fa * fb;
  end
`endif

  muldiv_iter_core u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (core_load),
    .step_i   (core_step),
    .funct3_i (f3_q),
    .neg_i    (neg_q),
    .op_i     (is_div ? m2 : m1),
    .lo_i     (is_div ? m1 : m2),
    .result_o (core_res)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    rd_d      = rd_q;
    rd_pend_d = rd_pend_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    core_load = 1'b0;
    core_step = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          if (div_zero | div_ovf) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = spec_res;
            rd_d     = rd_i;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = (funct3_i == F3_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
            rd_d     = rd_i;
`endif
          end else begin
            state_d   = CALC;
            cnt_d     = 5'(MULDIV_ITERS - 1);
            rd_pend_d = rd_i;
            f3_d      = funct3_i;
            neg_d     = neg_in;
            core_load = 1'b1;
          end
        end
        CALC: begin
          core_step = 1'b1;
          cnt_d     = cnt_q - 5'd1;
          if (cnt_q == '0) begin
            state_d  = DONE;
            cnt_d    = '0;
            valid_d  = 1'b1;
            result_d = core_res;
            rd_d     = rd_pend_q;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      rd_pend_q <= '0;
      f3_q      <= F3_MUL;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, special cases, flush, reset.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_chk = 0, n_fail = 0;

  muldiv_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  // Presents one op in the current cycle (caller is just past a negedge) and
  // observes a 40-cycle window. Drops start at once, or on valid when hold=1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit hold,
                       output int vcyc, output int nvalid, output int nbusy,
                       output logic [31:0] res, output logic [4:0] rdo);
    vcyc = -1; nvalid = 0; nbusy = 0; res = 'x; rdo = 'x;
    start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
    #1 if (busy_o) nbusy++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (!hold || valid_o) start_i = 1'b0;
      #1;
      if (busy_o) nbusy++;
      if (valid_o) begin
        nvalid++;
        if (vcyc < 0) begin vcyc = k; res = result_o; rdo = rd_o; end
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_chk++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_o); end
    n_chk++; if (rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", rd_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_divu();
    int vc, nv, nb; logic [31:0] r; logic [4:0] d;
    @(negedge clk_i); issue(F3_DIVU, 32'd100, 32'd7, 5'd4, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", vc); end
    n_chk++; if (nb !== 33) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want 33", nb); end
    n_chk++; if (nv !== 1) begin n_fail++; $display("FAIL divu_nvalid got %0d want 1", nv); end
    n_chk++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_result got %h want %h", r, 32'd14); end
    n_chk++; if (d !== 5'd4) begin n_fail++; $display("FAIL divu_rd got %0d want 4", d); end
    @(negedge clk_i); issue(F3_REMU, 32'd100, 32'd7, 5'd5, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 33 || r !== 32'd2) begin n_fail++; $display("FAIL remu got cyc %0d res %h want 33 %h", vc, r, 32'd2); end
  endtask

  task automatic test_signed();
    int vc, nv, nb; logic [31:0] r; logic [4:0] d;
    @(negedge clk_i); issue(F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 33 || r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg got cyc %0d res %h want 33 fffffffd", vc, r); end
    @(negedge clk_i); issue(F3_REM, 32'hFFFFFFF9, 32'd2, 5'd7, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 33 || r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_neg got cyc %0d res %h want 33 ffffffff", vc, r); end
    @(negedge clk_i); issue(F3_MULH, 32'h80000000, 32'h80000000, 5'd8, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== MUL_LAT || r !== 32'h40000000) begin n_fail++; $display("FAIL mulh got cyc %0d res %h want %0d 40000000", vc, r, MUL_LAT); end
    n_chk++; if (nb !== MUL_LAT) begin n_fail++; $display("FAIL mulh_busy got %0d want %0d", nb, MUL_LAT); end
  endtask

  task automatic test_special();
    int vc, nv, nb; logic [31:0] r; logic [4:0] d;
    @(negedge clk_i); issue(F3_DIV, 32'd5, 32'd0, 5'd9, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 1 || r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0 got cyc %0d res %h want 1 ffffffff", vc, r); end
    n_chk++; if (nb !== 1 || nv !== 1) begin n_fail++; $display("FAIL div0_busy got busy %0d valid %0d want 1 1", nb, nv); end
    n_chk++; if (d !== 5'd9) begin n_fail++; $display("FAIL div0_rd got %0d want 9", d); end
    @(negedge clk_i); issue(F3_REM, 32'h80000000, 32'hFFFFFFFF, 5'd10, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 1 || r !== 32'h0) begin n_fail++; $display("FAIL rem_ovf got cyc %0d res %h want 1 0", vc, r); end
    @(negedge clk_i); issue(F3_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 1 || r !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf got cyc %0d res %h want 1 80000000", vc, r); end
    @(negedge clk_i); issue(F3_REMU, 32'd5, 32'd0, 5'd12, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 1 || r !== 32'd5) begin n_fail++; $display("FAIL remu0 got cyc %0d res %h want 1 5", vc, r); end
    @(negedge clk_i); issue(F3_DIVU, 32'd5, 32'd0, 5'd13, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 1 || r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0 got cyc %0d res %h want 1 ffffffff", vc, r); end
  endtask

  task automatic test_mul();
    int vc, nv, nb; logic [31:0] r; logic [4:0] d;
    @(negedge clk_i); issue(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== MUL_LAT || r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu got cyc %0d res %h want %0d ffffffff", vc, r, MUL_LAT); end
    @(negedge clk_i); issue(F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== MUL_LAT || r !== 32'h1) begin n_fail++; $display("FAIL mul_m1 got cyc %0d res %h want %0d 1", vc, r, MUL_LAT); end
    @(negedge clk_i); issue(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 0, vc, nv, nb, r, d);
    n_chk++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu got %h want fffffffe", r); end
    @(negedge clk_i); issue(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd17, 0, vc, nv, nb, r, d);
    n_chk++; if (r !== 32'hFFFFFFEB || d !== 5'd17) begin n_fail++; $display("FAIL mul_neg got %h rd %0d want ffffffeb 17", r, d); end
  endtask

  task automatic test_back_to_back();
    int vc, nv, nb; logic [31:0] r; logic [4:0] d;
    @(negedge clk_i); issue(F3_DIVU, 32'd1000, 32'd10, 5'd18, 1, vc, nv, nb, r, d);
    n_chk++; if (nv !== 1 || vc !== 33) begin n_fail++; $display("FAIL held_start got valids %0d cyc %0d want 1 33", nv, vc); end
    n_chk++; if (r !== 32'd100) begin n_fail++; $display("FAIL held_start_result got %h want %h", r, 32'd100); end
  endtask

  task automatic test_flush();
    int vc, nv, nb, nkill; logic [31:0] r; logic [4:0] d;
    @(negedge clk_i); issue(F3_DIVU, 32'd100, 32'd7, 5'd3, 0, vc, nv, nb, r, d);
    // flush beats start in the same IDLE cycle
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = F3_DIVU; rs1_i = 32'd50; rs2_i = 32'd5; rd_i = 5'd20;
    #1;
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %b want 0", busy_o); end
    @(negedge clk_i); start_i = 1'b0; flush_i = 1'b0; #1;
    n_chk++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_accept got busy %b valid %b want 0 0", busy_o, valid_o); end
    // kill a DIV at T+10
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = F3_DIV; rs1_i = 32'd100; rs2_i = 32'hFFFFFFF9; rd_i = 5'd21;
    nkill = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (valid_o) nkill++;
      if (k == 10) flush_i = 1'b1;
    end
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i); #1;
    n_chk++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || nkill !== 0) begin n_fail++; $display("FAIL flush_idle got busy %b valid %b early %0d want 0 0 0", busy_o, valid_o, nkill); end
    n_chk++; if (result_o !== 32'd14 || rd_o !== 5'd3) begin n_fail++; $display("FAIL flush_hold got %h rd %0d want %h 3", result_o, rd_o, 32'd14); end
    issue(F3_DIVU, 32'd9, 32'd3, 5'd12, 0, vc, nv, nb, r, d);
    n_chk++; if (vc !== 33 || r !== 32'd3 || d !== 5'd12) begin n_fail++; $display("FAIL after_flush got cyc %0d res %h rd %0d want 33 3 12", vc, r, d); end
    n_chk++; if (nv !== 1) begin n_fail++; $display("FAIL after_flush_nvalid got %0d want 1", nv); end
  endtask

  task automatic test_reset_mid();
    int nv;
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = F3_MUL; rs1_i = 32'd3; rs2_i = 32'd5; rd_i = 5'd22;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (k == 5) rst_i = 1'b1;
    end
    @(negedge clk_i); #1;
    n_chk++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl got valid %b busy %b want 0 0", valid_o, busy_o); end
    n_chk++; if (result_o !== 32'h0 || rd_o !== 5'd0) begin n_fail++; $display("FAIL rst_mid_out got %h rd %0d want 0 0", result_o, rd_o); end
    rst_i = 1'b0;
    nv = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk_i); if (valid_o) nv++; end
    n_chk++; if (nv !== 0) begin n_fail++; $display("FAIL rst_mid_ghost got %0d valids want 0", nv); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_special();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the RV32M multiply/divide resource in the 5-stage pipeline. Accepts one M-extension op from the EX stage and runs an iterative radix-2 shift-add multiply or restoring divide over 32 cycles. Drives `busy_o` into hazard detection to freeze the pipeline. Returns a registered result with its destination register for writeback.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  EX holds a valid M-extension op.
- `funct3_i`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i`, `rs2_i`  in  XLEN  operand values, already forwarded.
- `rd_i`  in  5  destination register.
- `flush_i`  in  1  kill any op in flight (branch/exception).
- `busy_o`  out  1  stall request to hazard detection.
- `valid_o`  out  1  one-cycle result strobe.
- `result_o`  out  XLEN  result; held until the next accept.
- `rd_o`  out  5  destination of `result_o`.

## Operation
- **States:**
  - IDLE
  - CALC, with a 5-bit counter `cnt`
  - DONE
- **Accept:** `start_i & (state==IDLE) & ~flush_i`. Registers operand magnitudes, sign fixups, funct3 and rd.
- **Start while not IDLE:** `start_i` is ignored. The pipeline is stalled, so the same op is re-presented after `valid_o`.
- **IDLE → CALC:** on a normal accept, with `cnt` loaded to 31.
- **CALC:** one iteration per cycle, `cnt` decrements. CALC → DONE when `cnt==0` completes.
- **IDLE → DONE directly (special cases):**
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): DIV → 0x80000000, REM → 0.
- **DONE:**
  - `valid_o`=1 for exactly one cycle, then → IDLE.
  - `result_o`/`rd_o` update on entry to DONE and hold afterwards.
- **Multiply:**
  - 64-bit accumulator; unsigned magnitude product, negated when signs differ.
  - MULHSU treats rs2 as unsigned.
  - MUL returns [31:0]; MULH* return [63:32].
- **Divide:**
  - Unsigned restoring divide on magnitudes.
  - Quotient negated if the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- **`busy_o`:** `(state==CALC) | (state==IDLE & start_i & ~flush_i)`.
  - Combinational, so the stall lands in the accept cycle.
  - Low in DONE, so EX/MEM captures the result that cycle.
- **Flush:**
  - `flush_i` in any state → IDLE next cycle; no `valid_o`.
  - Flush wins over `start_i` in the same cycle.
  - `result_o`/`rd_o` are not cleared.
- **Reset:** state=IDLE, `cnt`=0, `busy_o`=0, `valid_o`=0, `result_o`=0, `rd_o`=0.

## Timing
- **Accept in cycle T, normal op:**
  - CALC occupies T+1..T+32.
  - `valid_o` is high in T+33.
  - `busy_o` is high T..T+32.
- **Special case:** `valid_o` in T+1; `busy_o` high in T only.
- **Back-to-back ops:** the next accept is no earlier than the cycle after DONE.
- **Flush timing:**
  - Flush in cycle F → state IDLE in F+1.
  - A new op can be accepted in F+1.
- **Reset mid-operation:** same result as a flush, plus outputs cleared.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:**
  - Multiplies use a single-cycle 33x33 signed multiplier: IDLE → DONE, `valid_o` at T+1.
  - Divides are unchanged.
- **Undefined:** multiplies take the 32-cycle iterative path.

## Structure
- **`muldiv_pkg`:**
  - funct3 localparams (`F3_MUL` … `F3_REMU`)
  - state enum `muldiv_state_t` {IDLE, CALC, DONE}
  - `XLEN`
  - `MULDIV_ITERS`=32
- **`muldiv_iter_core`:** one natural sub-module.
  - Holds the 64-bit accumulator/remainder register, the shift/add-subtract step and the final sign correction.
  - `muldiv_ctrl` keeps the FSM, counter, special-case detect and output registers.

## Test plan
- DIVU 100/7 accepted at T → `busy_o` high T..T+32, `valid_o` at T+33, result 14; REMU → 2.
- DIV -7/2 → -3 (0xFFFFFFFD); REM -7/2 → -1; MULH 0x80000000×0x80000000 → 0x40000000.
- DIV 5/0 → 0xFFFFFFFF at T+1; REM 0x80000000/0xFFFFFFFF → 0 at T+1.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MUL → 0x00000001. With `MULDIV_FAST_MUL_EN`: `valid_o` at T+1.
- `flush_i` at T+10 of a DIV → IDLE at T+11, no `valid_o`, previous `result_o` held. DIVU 9/3 accepted at T+11 → 3 at T+44.
- `rst_i` at T+5 of MUL → all outputs 0 next cycle. `start_i` held high during CALC → single accept, single `valid_o`.
